wb8_master_arbiter: RTL and testbench
=====================================

# wb8_master_arbiter

Two-master arbiter for the 8-bit Wishbone system bus. It lets the SPU32 CPU (master 0) and a second bus master, such as a DMA or blitter engine (master 1), share the single slave-side bus that feeds the address decoder and peripherals. It grants the bus round-robin on a per-cycle (CYC) basis and multiplexes the granted master's signals onto the slave bus. A bus watchdog terminates any access that no slave acknowledges, so a hung master cannot freeze the system.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles a strobed access may wait for I_s_ack before the arbiter terminates it; legal range 2..65535.
- ADRBITS, 32: address width.

Ports:
- I_wb_clk, in, 1: bus clock; the only clock.
- I_reset_n, in, 1: reset, synchronous, active-low.
- I_m0_cyc, I_m0_stb, I_m0_we, in, 1 each: master 0 cycle, strobe and write enable.
- I_m0_adr, in, ADRBITS: master 0 address.
- I_m0_dat, in, 8: master 0 write data.
- O_m0_dat, out, 8: read data to master 0.
- O_m0_ack, O_m0_stall, O_m0_err, out, 1 each: master 0 acknowledge, stall and error.
- I_m1_* and O_m1_*: identical set for master 1.
- O_s_cyc, O_s_stb, O_s_we, out, 1 each: slave-side cycle, strobe and write enable (to the address decoder).
- O_s_adr, out, ADRBITS: slave-side address.
- O_s_dat, out, 8: slave-side write data.
- I_s_dat, in, 8: read data from the decoder.
- I_s_ack, I_s_stall, in, 1 each: acknowledge and stall from the decoder.
- O_timeout_flag, out, 1: sticky flag, set on any watchdog termination and cleared only by reset.

## Operation
- State machine with states IDLE, GRANT0 and GRANT1, held in a registered `grant` value. A `last` register records the most recently granted master.
- IDLE:
  - Only one master has cyc high: go to that master's grant state.
  - Both masters have cyc high: grant the master that is not `last`.
  - Neither has cyc high: stay in IDLE.
- GRANTn:
  - Held while I_mn_cyc=1.
  - When I_mn_cyc falls and the other master has cyc high, hand over directly to the other grant state.
  - When I_mn_cyc falls and the other master is idle, go to IDLE.
  - `last` updates to n on every entry to GRANTn.
- Slave bus mux (combinational from `grant`):
  - O_s_cyc/stb/we/adr/dat come from the granted master.
  - In IDLE, O_s_cyc and O_s_stb are 0 and the remaining slave outputs are 0.
- Master return paths:
  - O_mn_dat = I_s_dat when granted, else 0.
  - O_mn_ack = I_s_ack when granted, else 0.
  - O_mn_stall = I_s_stall when granted; forced to 1 when not granted and I_mn_cyc=1.
- Watchdog:
  - Counter width is $clog2(TIMEOUT+1).
  - Clears on I_s_ack, on any grant change, and whenever O_s_stb=0.
  - Increments each cycle that O_s_stb=1 and I_s_ack=0.
  - When the count reaches TIMEOUT-1 with no ack, the next cycle is a termination cycle:
    - O_s_stb is forced to 0.
    - The granted master receives O_mn_ack=1, O_mn_err=1 and O_mn_dat=8'hFF.
    - O_timeout_flag is set.
    - The counter clears.
- O_mn_err is a single-cycle pulse and is never asserted except on termination.

## Timing
- Reset (I_reset_n=0 at a clock edge):
  - grant=IDLE, last=1 (so master 0 wins the first tie), counter=0, O_timeout_flag=0.
  - All O_s_* and O_m*_ack/err/dat are 0 the following cycle.
  - O_mn_stall=1 while I_mn_cyc=1.
- Reset mid-transfer abandons the transfer with no ack and no err.
- Grant latency: 1 cycle from a cyc rise in IDLE to O_s_cyc. Handover takes 1 cycle with no IDLE gap.
- Data path and ack are combinational pass-through with zero added latency once granted.
- Watchdog: with no ack, the termination ack arrives exactly TIMEOUT cycles after the first cycle O_s_stb is high.
- Simultaneous events:
  - I_s_ack in the same cycle the counter hits TIMEOUT-1 counts as a normal ack; no error.
  - A cyc drop coinciding with the termination cycle still delivers the err pulse and then releases.

## Structure
- A shared package `wb8_pkg` holds:
  - the grant state encodings GNT_IDLE, GNT_M0 and GNT_M1;
  - the error return byte WB8_ERR_DATA = 8'hFF.
- Sub-module `wb8_watchdog` contains the timeout counter and termination logic. Its inputs are stb, ack and clear; its outputs are the terminate pulse and the sticky flag. It is reusable for single-master boards.
- The grant FSM and mux stay in the top level of this block.

## Test plan
- M0-only read at 0xFFFFF800, slave acks in cycle 2 with 0x5A → O_s_cyc rises 1 cycle after I_m0_cyc; O_m0_dat=0x5A with O_m0_ack; O_m1_* stays 0.
- M0 and M1 raise cyc in the same cycle right after reset → M0 is granted and M1 sees stall=1. M0 drops cyc, then M1 is granted on the next cycle with no IDLE cycle. When both request again, M0 is granted (M1 was last).
- M1 holds cyc for a 4-byte burst while M0 requests → M0 stays stalled for the whole burst and is granted 1 cycle after M1 drops cyc.
- TIMEOUT=8, M0 writes to an address no slave acks → exactly 8 cycles after stb: O_m0_ack=1, O_m0_err=1, O_m0_dat=0xFF, O_s_stb=0. O_timeout_flag stays 1 until reset.
- Ack arrives on the final cycle before timeout (cycle 8 with TIMEOUT=8) → normal ack, err=0, flag stays 0.
- I_reset_n pulled low mid-transfer while GRANT1 → next cycle all outputs are at reset values, grant=IDLE, no ack or err to M1.

Source files
------------

// File: rtl/wb8_pkg.sv
// Shared constants for the 8-bit Wishbone bus blocks: grant encodings and
// the read data returned on a watchdog-terminated access.
package wb8_pkg;

  localparam logic [1:0] GNT_IDLE = 2'd0;
  localparam logic [1:0] GNT_M0   = 2'd1;
  localparam logic [1:0] GNT_M1   = 2'd2;

  localparam logic [7:0] WB8_ERR_DATA = 8'hFF;

endpackage

// File: rtl/wb8_watchdog.sv
// Bus watchdog: counts strobed cycles without an ack and emits a one-cycle
// terminate pulse after TIMEOUT cycles, plus a sticky flag cleared by reset.
module wb8_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stb,
  input  logic ack,
  input  logic clear,
  output logic terminate,
  output logic timeout_flag
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          expire;

  // An ack or grant change in the final counting cycle wins over expiry.
  assign expire = stb && !ack && !clear && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      terminate    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      terminate <= expire;
      if (expire)
        timeout_flag <= 1'b1;
      if (clear || ack || !stb || expire)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb8_master_arbiter.sv
// Round-robin two-master arbiter for the 8-bit Wishbone bus with a watchdog
// that terminates unacknowledged accesses with an error.
module wb8_master_arbiter
  import wb8_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADRBITS = 32
) (
  input  logic               I_wb_clk,
  input  logic               I_reset_n,
  input  logic               I_m0_cyc,
  input  logic               I_m0_stb,
  input  logic               I_m0_we,
  input  logic [ADRBITS-1:0] I_m0_adr,
  input  logic [7:0]         I_m0_dat,
  output logic [7:0]         O_m0_dat,
  output logic               O_m0_ack,
  output logic               O_m0_stall,
  output logic               O_m0_err,
  input  logic               I_m1_cyc,
  input  logic               I_m1_stb,
  input  logic               I_m1_we,
  input  logic [ADRBITS-1:0] I_m1_adr,
  input  logic [7:0]         I_m1_dat,
  output logic [7:0]         O_m1_dat,
  output logic               O_m1_ack,
  output logic               O_m1_stall,
  output logic               O_m1_err,
  output logic               O_s_cyc,
  output logic               O_s_stb,
  output logic               O_s_we,
  output logic [ADRBITS-1:0] O_s_adr,
  output logic [7:0]         O_s_dat,
  input  logic [7:0]         I_s_dat,
  input  logic               I_s_ack,
  input  logic               I_s_stall,
  output logic               O_timeout_flag,
  output logic [1:0]         dbg_grant
);

  // Handshake: a master owns the slave bus while granted and its cyc is high;
  // ack/stall/dat pass straight through, a non-granted requester sees stall=1.
  logic [1:0] grant;
  logic [1:0] grant_nxt;
  logic       last;
  logic       sel0;
  logic       sel1;
  logic       stb_raw;
  logic       wd_term;
  logic       wd_clear;

  always_comb begin
    grant_nxt = grant;
    case (grant)
      GNT_M0: if (!I_m0_cyc) grant_nxt = I_m1_cyc ? GNT_M1 : GNT_IDLE;
      GNT_M1: if (!I_m1_cyc) grant_nxt = I_m0_cyc ? GNT_M0 : GNT_IDLE;
      default: begin
        if (I_m0_cyc && I_m1_cyc) grant_nxt = last ? GNT_M0 : GNT_M1;
        else if (I_m0_cyc)        grant_nxt = GNT_M0;
        else if (I_m1_cyc)        grant_nxt = GNT_M1;
        else                      grant_nxt = GNT_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_wb_clk) begin
    if (!I_reset_n) begin
      grant <= GNT_IDLE;
      last  <= 1'b1;
    end else begin
      grant <= grant_nxt;
      if (grant_nxt == GNT_M0) last <= 1'b0;
      else if (grant_nxt == GNT_M1) last <= 1'b1;
    end
  end

  assign sel0      = (grant == GNT_M0);
  assign sel1      = (grant == GNT_M1);
  assign dbg_grant = grant;
  assign wd_clear  = (grant_nxt != grant);

  always_comb begin
    O_s_cyc = 1'b0;
    stb_raw = 1'b0;
    O_s_we  = 1'b0;
    O_s_adr = '0;
    O_s_dat = 8'h00;
    if (sel0) begin
      O_s_cyc = I_m0_cyc;
      stb_raw = I_m0_stb;
      O_s_we  = I_m0_we;
      O_s_adr = I_m0_adr;
      O_s_dat = I_m0_dat;
    end else if (sel1) begin
      O_s_cyc = I_m1_cyc;
      stb_raw = I_m1_stb;
      O_s_we  = I_m1_we;
      O_s_adr = I_m1_adr;
      O_s_dat = I_m1_dat;
    end
  end

  // The termination cycle withdraws the strobe so the slave sees no access.
  assign O_s_stb = stb_raw & ~wd_term;

  assign O_m0_dat   = sel0 ? (wd_term ? WB8_ERR_DATA : I_s_dat) : 8'h00;
  assign O_m0_ack   = sel0 & (I_s_ack | wd_term);
  assign O_m0_err   = sel0 & wd_term;
  assign O_m0_stall = sel0 ? (I_s_stall & ~wd_term) : I_m0_cyc;

  assign O_m1_dat   = sel1 ? (wd_term ? WB8_ERR_DATA : I_s_dat) : 8'h00;
  assign O_m1_ack   = sel1 & (I_s_ack | wd_term);
  assign O_m1_err   = sel1 & wd_term;
  assign O_m1_stall = sel1 ? (I_s_stall & ~wd_term) : I_m1_cyc;

  wb8_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk          (I_wb_clk),
    .reset_n      (I_reset_n),
    .stb          (O_s_stb),
    .ack          (I_s_ack),
    .clear        (wd_clear),
    .terminate    (wd_term),
    .timeout_flag (O_timeout_flag)
  );

endmodule

// File: tb/tb_wb8_master_arbiter.sv
// Directed bench for wb8_master_arbiter with TIMEOUT=8: arbitration,
// handover, burst stalling, watchdog termination and reset abandonment.
module tb_wb8_master_arbiter;

  localparam int TIMEOUT = 8;
  localparam int ADRBITS = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               m0_cyc, m0_stb, m0_we;
  logic [ADRBITS-1:0] m0_adr;
  logic [7:0]         m0_wdat, m0_rdat;
  logic               m0_ack, m0_stall, m0_err;
  logic               m1_cyc, m1_stb, m1_we;
  logic [ADRBITS-1:0] m1_adr;
  logic [7:0]         m1_wdat, m1_rdat;
  logic               m1_ack, m1_stall, m1_err;
  logic               s_cyc, s_stb, s_we;
  logic [ADRBITS-1:0] s_adr;
  logic [7:0]         s_wdat, s_rdat;
  logic               s_ack, s_stall;
  logic               to_flag;
  logic [1:0]         grant;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  wb8_master_arbiter #(.TIMEOUT(TIMEOUT), .ADRBITS(ADRBITS)) dut (
    .I_wb_clk(clk), .I_reset_n(rst_n),
    .I_m0_cyc(m0_cyc), .I_m0_stb(m0_stb), .I_m0_we(m0_we),
    .I_m0_adr(m0_adr), .I_m0_dat(m0_wdat), .O_m0_dat(m0_rdat),
    .O_m0_ack(m0_ack), .O_m0_stall(m0_stall), .O_m0_err(m0_err),
    .I_m1_cyc(m1_cyc), .I_m1_stb(m1_stb), .I_m1_we(m1_we),
    .I_m1_adr(m1_adr), .I_m1_dat(m1_wdat), .O_m1_dat(m1_rdat),
    .O_m1_ack(m1_ack), .O_m1_stall(m1_stall), .O_m1_err(m1_err),
    .O_s_cyc(s_cyc), .O_s_stb(s_stb), .O_s_we(s_we),
    .O_s_adr(s_adr), .O_s_dat(s_wdat), .I_s_dat(s_rdat),
    .I_s_ack(s_ack), .I_s_stall(s_stall),
    .O_timeout_flag(to_flag), .dbg_grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = 8'h00;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = 8'h00;
    s_rdat = 8'h00; s_ack = 0; s_stall = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    check("rst_s_stb", {31'd0, s_stb}, 32'd0);
    check("rst_s_adr", s_adr, 32'd0);
    check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    check("rst_flag", {31'd0, to_flag}, 32'd0);

    // M0-only read
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hFFFF_F800;
    #1;
    check("t1_idle_s_cyc", {31'd0, s_cyc}, 32'd0);
    check("t1_idle_m0_stall", {31'd0, m0_stall}, 32'd1);
    tick();
    check("t1_s_cyc", {31'd0, s_cyc}, 32'd1);
    check("t1_s_adr", s_adr, 32'hFFFF_F800);
    check("t1_m0_ack_wait", {31'd0, m0_ack}, 32'd0);
    tick();
    s_ack = 1; s_rdat = 8'h5A;
    #1;
    check("t1_m0_ack", {31'd0, m0_ack}, 32'd1);
    check("t1_m0_dat", {24'd0, m0_rdat}, 32'h5A);
    check("t1_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("t1_m1_dat", {24'd0, m1_rdat}, 32'h0);
    check("t1_m1_stall", {31'd0, m1_stall}, 32'd0);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0; s_rdat = 8'h00;
    tick();
    check("t1_release", {30'd0, grant}, 32'd0);

    // Simultaneous request after reset, handover, then round-robin tie
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check("t2_grant_m0", {30'd0, grant}, 32'd1);
    check("t2_m1_stall", {31'd0, m1_stall}, 32'd1);
    check("t2_m0_stall", {31'd0, m0_stall}, 32'd0);
    m0_cyc = 0;
    tick();
    check("t2_handover", {30'd0, grant}, 32'd2);
    check("t2_h_s_cyc", {31'd0, s_cyc}, 32'd1);
    check("t2_h_m1_stall", {31'd0, m1_stall}, 32'd0);
    m1_cyc = 0;
    tick();
    check("t2_idle", {30'd0, grant}, 32'd0);
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check("t2_tie_m0", {30'd0, grant}, 32'd1);
    m0_cyc = 0; m1_cyc = 0;
    tick();
    tick();
    check("t2_end_idle", {30'd0, grant}, 32'd0);

    // M1 4-byte burst while M0 waits
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0100;
    tick();
    check("t3_grant_m1", {30'd0, grant}, 32'd2);
    m0_cyc = 1;
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h0000_0100 + 32'(i);
      s_ack = 1; s_rdat = 8'hC0 + 8'(i);
      exp_q.push_back(8'hC0 + 8'(i));
      #1;
      check("t3_m1_dat", {24'd0, m1_rdat}, {24'd0, exp_q.pop_front()});
      check("t3_s_adr", s_adr, 32'h0000_0100 + 32'(i));
      check("t3_m0_stall", {31'd0, m0_stall}, 32'd1);
      check("t3_m0_ack", {31'd0, m0_ack}, 32'd0);
      tick();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0; s_rdat = 8'h00;
    #1;
    check("t3_drop_m0_stall", {31'd0, m0_stall}, 32'd1);
    tick();
    check("t3_grant_m0", {30'd0, grant}, 32'd1);
    check("t3_m0_unstall", {31'd0, m0_stall}, 32'd0);
    m0_cyc = 0;
    tick();

    // Watchdog termination of an unacknowledged M0 write
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_1234; m0_wdat = 8'hA5;
    tick();
    check("t4_s_stb", {31'd0, s_stb}, 32'd1);
    check("t4_s_we", {31'd0, s_we}, 32'd1);
    check("t4_s_dat", {24'd0, s_wdat}, 32'hA5);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      check("t4_wait_ack", {31'd0, m0_ack}, 32'd0);
      check("t4_wait_err", {31'd0, m0_err}, 32'd0);
      check("t4_wait_stb", {31'd0, s_stb}, 32'd1);
    end
    tick();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1;
    check("t4_term_ack", {31'd0, m0_ack}, 32'd1);
    check("t4_term_err", {31'd0, m0_err}, 32'd1);
    check("t4_term_dat", {24'd0, m0_rdat}, 32'hFF);
    check("t4_term_stb", {31'd0, s_stb}, 32'd0);
    check("t4_term_flag", {31'd0, to_flag}, 32'd1);
    tick();
    check("t4_post_err", {31'd0, m0_err}, 32'd0);
    check("t4_post_ack", {31'd0, m0_ack}, 32'd0);
    check("t4_post_grant", {30'd0, grant}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_flag_sticky", {31'd0, to_flag}, 32'd1);
    end

    // Reset in the middle of an M1 transfer
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_2000; m1_wdat = 8'h77;
    tick();
    check("t6_grant_m1", {30'd0, grant}, 32'd2);
    check("t6_s_stb", {31'd0, s_stb}, 32'd1);
    rst_n = 0;
    tick();
    check("t6_grant", {30'd0, grant}, 32'd0);
    check("t6_s_cyc", {31'd0, s_cyc}, 32'd0);
    check("t6_s_stb0", {31'd0, s_stb}, 32'd0);
    check("t6_s_adr", s_adr, 32'd0);
    check("t6_s_we", {31'd0, s_we}, 32'd0);
    check("t6_s_dat", {24'd0, s_wdat}, 32'd0);
    check("t6_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("t6_m1_err", {31'd0, m1_err}, 32'd0);
    check("t6_m1_dat", {24'd0, m1_rdat}, 32'd0);
    check("t6_m1_stall", {31'd0, m1_stall}, 32'd1);
    check("t6_flag", {31'd0, to_flag}, 32'd0);
    rst_n = 1;
    idle_inputs();
    tick();

    // Ack on the last cycle before expiry is a normal ack
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0040;
    tick();
    for (int k = 1; k < TIMEOUT; k++) tick();
    s_ack = 1; s_rdat = 8'h33;
    #1;
    check("t5_ack", {31'd0, m0_ack}, 32'd1);
    check("t5_err", {31'd0, m0_err}, 32'd0);
    check("t5_dat", {24'd0, m0_rdat}, 32'h33);
    tick();
    s_ack = 0; s_rdat = 8'h00; m0_cyc = 0; m0_stb = 0;
    #1;
    check("t5_next_err", {31'd0, m0_err}, 32'd0);
    check("t5_next_ack", {31'd0, m0_ack}, 32'd0);
    check("t5_next_flag", {31'd0, to_flag}, 32'd0);
    tick();
    check("t5_end_flag", {31'd0, to_flag}, 32'd0);
    check("t5_end_grant", {30'd0, grant}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
